// File: rtl/rf_pkg.sv
// Shared sizing and grant encoding for the register-file writeback path.
package rf_pkg;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // Which writeback source won the most recent transfer.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, set at issue,
// cleared at writeback transfer. Register 0 is never busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = rf_pkg::AW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          IssEn,
  input  logic [AW-1:0] IssRd,
  input  logic          ClrEn,
  input  logic [AW-1:0] ClrRd,
  input  logic          WrEn,
  input  logic [AW-1:0] Rw,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic          BusyA,
  output logic          BusyB
);

  logic [NREG-1:0] busy;

  assign busy[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : gBit
    logic setHit, clrHit;
    assign setHit = IssEn && (IssRd == AW'(g));
    assign clrHit = ClrEn && (ClrRd == AW'(g));

    // Per-register busy bit; a same-edge set overrides the clear.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)         busy[g] <= 1'b0;
      else if (setHit) busy[g] <= 1'b1;
      else if (clrHit) busy[g] <= 1'b0;
    end
  end

  // Hazard lookup: still busy, or the write is sitting in the output register
  // this cycle and has not reached the register file yet.
  always_comb begin
    BusyA = (Ra != '0) && (busy[Ra] || (WrEn && (Rw == Ra)));
    BusyB = (Rb != '0) && (busy[Rb] || (WrEn && (Rw == Rb)));
  end

endmodule

// File: rtl/rf_wb_arb.sv
// Writeback arbiter: round-robin between ALU and load results, one register
// file write per cycle, registered write port, plus the busy scoreboard.
module rf_wb_arb
  import rf_pkg::*;
#(
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = rf_pkg::AW,
  parameter int DW   = rf_pkg::DW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          AluVld,
  output logic          AluRdy,
  input  logic [AW-1:0] AluRw,
  input  logic [DW-1:0] AluBus,
  input  logic          MemVld,
  output logic          MemRdy,
  input  logic [AW-1:0] MemRw,
  input  logic [DW-1:0] MemBus,
  input  logic          IssEn,
  input  logic [AW-1:0] IssRd,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic          BusyA,
  output logic          BusyB,
  output logic          WrEn,
  output logic [AW-1:0] Rw,
  output logic [DW-1:0] busW
);

  grant_e        lastGnt;
  logic          xfer;
  logic [AW-1:0] winRw;
  logic [DW-1:0] winBus;

  // Grant: lone requester wins; on conflict the side not granted last wins.
  always_comb begin
    AluRdy = 1'b0;
    MemRdy = 1'b0;
    if (!Rst) begin
      if (AluVld && MemVld) begin
        if (lastGnt == GNT_ALU) MemRdy = 1'b1;
        else                    AluRdy = 1'b1;
      end else begin
        AluRdy = AluVld;
        MemRdy = MemVld;
      end
    end
  end

  assign xfer   = AluRdy || MemRdy;
  assign winRw  = MemRdy ? MemRw  : AluRw;
  assign winBus = MemRdy ? MemBus : AluBus;

  // Round-robin pointer only moves when a transfer actually happens.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)       lastGnt <= GNT_ALU;
    else if (xfer) lastGnt <= MemRdy ? GNT_MEM : GNT_ALU;
  end

  // Register-file write port; writes to r0 are accepted but never enabled.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      WrEn <= 1'b0;
      Rw   <= '0;
      busW <= '0;
    end else if (xfer) begin
      WrEn <= (winRw != '0);
      Rw   <= winRw;
      busW <= winBus;
    end else begin
      WrEn <= 1'b0;
    end
  end

  rf_scoreboard #(.NREG(NREG), .AW(AW)) uSb (
    .Clk   (Clk),
    .Rst   (Rst),
    .IssEn (IssEn && (IssRd != '0)),
    .IssRd (IssRd),
    .ClrEn (xfer && (winRw != '0)),
    .ClrRd (winRw),
    .WrEn  (WrEn),
    .Rw    (Rw),
    .Ra    (Ra),
    .Rb    (Rb),
    .BusyA (BusyA),
    .BusyB (BusyB)
  );

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios plus random traffic, all checked
// against a transaction-level model of grants, pending writes and busy regs.
module tb_rf_wb_arb;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          AluVld = 1'b0, MemVld = 1'b0, IssEn = 1'b0;
  logic [AW-1:0] AluRw = '0, MemRw = '0, IssRd = '0, Ra = '0, Rb = '0;
  logic [DW-1:0] AluBus = '0, MemBus = '0;
  logic          AluRdy, MemRdy, BusyA, BusyB, WrEn;
  logic [AW-1:0] Rw;
  logic [DW-1:0] busW;

  rf_wb_arb #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .AluVld(AluVld), .AluRdy(AluRdy), .AluRw(AluRw), .AluBus(AluBus),
    .MemVld(MemVld), .MemRdy(MemRdy), .MemRw(MemRw), .MemBus(MemBus),
    .IssEn(IssEn), .IssRd(IssRd), .Ra(Ra), .Rb(Rb),
    .BusyA(BusyA), .BusyB(BusyB),
    .WrEn(WrEn), .Rw(Rw), .busW(busW)
  );

  always #5 Clk = ~Clk;

  int nChk = 0;
  int nPass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
  endtask

  // Reference model state
  bit          mBusy[NREG];
  bit          memWasLast;      // 1 when the load side won the last transfer
  bit          mWrEn;
  int          mRw;
  logic [31:0] mBus;
  bit          mDataKnown;      // write data/index meaningful to compare
  // Observations from the last cycle, for directed checks
  logic        oAluRdy, oMemRdy, oBusyA, oBusyB;

  function automatic void modelReset();
    foreach (mBusy[i]) mBusy[i] = 1'b0;
    memWasLast = 1'b0;
    mWrEn = 1'b0;
    mRw = 0;
    mBus = '0;
    mDataKnown = 1'b1;
  endfunction

  function automatic bit expBusy(input int r);
    if (r == 0) return 1'b0;
    return mBusy[r] || (mWrEn && mRw == r);
  endfunction

  // One clock of traffic: drive, check combinational outputs, advance the
  // model across the edge, check the registered write port.
  task automatic cyc(input bit av, input int arw, input logic [31:0] abus,
                     input bit mv, input int mrw, input logic [31:0] mbus,
                     input bit ie, input int ird, input int ra, input int rb);
    bit eA, eM, xf;
    int wRw;
    logic [31:0] wBus;
    @(negedge Clk);
    AluVld = av; AluRw = AW'(arw); AluBus = abus;
    MemVld = mv; MemRw = AW'(mrw); MemBus = mbus;
    IssEn = ie; IssRd = AW'(ird); Ra = AW'(ra); Rb = AW'(rb);
    #1;
    // Conflict goes to whichever side did not win last time.
    if (av && mv) begin eM = !memWasLast; eA = memWasLast; end
    else begin eA = av; eM = mv; end
    oAluRdy = AluRdy; oMemRdy = MemRdy; oBusyA = BusyA; oBusyB = BusyB;
    chk("aluRdy", AluRdy, eA);
    chk("memRdy", MemRdy, eM);
    chk("busyA", BusyA, expBusy(ra));
    chk("busyB", BusyB, expBusy(rb));
    xf = eA || eM;
    wRw = eM ? mrw : arw;
    wBus = eM ? mbus : abus;
    if (xf) memWasLast = eM;
    if (xf && wRw != 0) mBusy[wRw] = 1'b0;
    if (ie && ird != 0) mBusy[ird] = 1'b1;
    mWrEn = xf && (wRw != 0);
    if (xf) begin
      mRw = wRw; mBus = wBus; mDataKnown = (wRw != 0);
    end
    @(posedge Clk);
    #1;
    chk("wrEn", WrEn, mWrEn);
    if (mDataKnown) begin
      chk("rw", Rw, mRw);
      chk("busW", busW, mBus);
    end
  endtask

  task automatic idle(input int ra);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ra, 0);
  endtask

  // Reset with both requesters asserted to confirm grants are suppressed.
  task automatic rstDut(input int ra);
    @(negedge Clk);
    Rst = 1'b1; AluVld = 1'b1; MemVld = 1'b1; IssEn = 1'b0; Ra = AW'(ra); Rb = '0;
    #1;
    chk("rstWrEn", WrEn, 0);
    chk("rstRw", Rw, 0);
    chk("rstBusW", busW, 0);
    chk("rstAluRdy", AluRdy, 0);
    chk("rstMemRdy", MemRdy, 0);
    chk("rstBusyA", BusyA, 0);
    @(posedge Clk);
    #1;
    chk("rstHoldWrEn", WrEn, 0);
    @(negedge Clk);
    Rst = 1'b0; AluVld = 1'b0; MemVld = 1'b0;
    modelReset();
  endtask

  initial begin
    modelReset();
    rstDut(0);

    // Lone ALU request
    cyc(1, 18, 32'h0000_000A, 0, 0, 0, 0, 0, 0, 0);
    chk("d41rdy", oAluRdy, 1);
    chk("d41wr", WrEn, 1);
    chk("d41rw", Rw, 18);
    chk("d41bus", busW, 32'h0000_000A);

    // Conflict ordering from reset: Mem, Alu, Mem
    rstDut(0);
    cyc(1, 20, 32'h3000, 1, 19, 32'h2, 0, 0, 0, 0);
    chk("d42g0mem", oMemRdy, 1);
    chk("d42wr0", WrEn, 1);
    cyc(1, 20, 32'h3000, 1, 19, 32'h2, 0, 0, 0, 0);
    chk("d42g1alu", oAluRdy, 1);
    chk("d42wr1", WrEn, 1);
    cyc(1, 20, 32'h3000, 1, 19, 32'h2, 0, 0, 0, 0);
    chk("d42g2mem", oMemRdy, 1);
    chk("d42wr2", WrEn, 1);

    // Busy lifetime of r17 through issue, transfer and write cycle
    cyc(0, 0, 0, 0, 0, 0, 1, 17, 0, 0);
    cyc(1, 17, 32'h55, 0, 0, 0, 0, 0, 17, 0);
    chk("d43issued", oBusyA, 1);
    idle(17);
    chk("d43wrCycle", oBusyA, 1);
    idle(17);
    chk("d43cleared", oBusyA, 0);

    // Same-edge set and clear of r5: set wins
    cyc(1, 5, 32'h77, 0, 0, 0, 1, 5, 0, 0);
    idle(5);
    idle(5);
    chk("d44setWins", oBusyA, 1);

    // Load to r0: granted, no write
    cyc(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("d45rdy", oMemRdy, 1);
    chk("d45wr", WrEn, 0);
    idle(0);
    chk("d45busyR0", oBusyA, 0);

    // Reset right after a transfer to r8 drops the pending write
    cyc(0, 0, 0, 0, 0, 0, 1, 8, 0, 0);
    cyc(1, 8, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("d46wrBefore", WrEn, 1);
    rstDut(8);
    idle(8);
    chk("d46busyA", oBusyA, 0);
    chk("d46noWr", WrEn, 0);

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if (i == 200) rstDut($urandom_range(0, 7));
      cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
          $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7));
    end

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 Parameter NREG, 32, number of architectural registers.
REQ-002 Parameter AW, 5, register-index width.
REQ-003 Parameter DW, 32, data width.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Rst  in  1  asynchronous, active-high reset.
REQ-006 AluVld  in  1  ALU writeback request valid.
REQ-007 AluRdy  out  1  ALU request granted this cycle (combinational).
REQ-008 AluRw  in  AW  ALU destination register.
REQ-009 AluBus  in  DW  ALU result.
REQ-010 MemVld  in  1  load writeback request valid.
REQ-011 MemRdy  out  1  load request granted this cycle (combinational).
REQ-012 MemRw  in  AW  load destination register.
REQ-013 MemBus  in  DW  load data.
REQ-014 IssEn  in  1  an instruction with a destination register issues this cycle.
REQ-015 IssRd  in  AW  destination of the issuing instruction.
REQ-016 Ra, Rb  in  AW each  source indices under hazard query.
REQ-017 BusyA, BusyB  out  1 each  source has an outstanding write (combinational).
REQ-018 WrEn  out  1  register-file write enable (registered).
REQ-019 Rw  out  AW  register-file write index (registered).
REQ-020 busW  out  DW  register-file write data (registered).

Function
REQ-021 Transfer occurs when Vld and Rdy are both high on a rising edge; at most one transfer per cycle.
REQ-022 Rdy depends only on both Vld inputs and the last-grant flag; it does not depend on Rdy of the other port.
REQ-023 Single request: that requester is granted.
REQ-024 Both requests: the requester not granted last is granted (round-robin); the last-grant flag updates only on a transfer.
REQ-025 Round-robin guarantees that a held request waits at most one cycle.
REQ-026 Latency: the transfer at edge N drives WrEn=1, Rw and busW from the winner for the cycle after edge N.
REQ-027 Without a transfer, WrEn=0 in the next cycle; Rw and busW hold their previous values.
REQ-028 Transfer with Rw=0: the request is accepted, WrEn stays 0 and the scoreboard is unchanged.
REQ-029 Scoreboard: NREG-bit busy vector; bit 0 is constantly 0.
REQ-030 IssEn=1 with IssRd!=0 sets busy[IssRd] at the edge.
REQ-031 A transfer with Rw!=0 clears busy[Rw] at the edge.
REQ-032 Set and clear of the same register at the same edge: set wins.
REQ-033 BusyA = busy[Ra] OR (WrEn AND Rw==Ra AND Ra!=0); BusyB is the same with Rb.
REQ-034 Ra=0 or Rb=0 always reports not busy.
REQ-035 A transfer to a register whose busy bit is 0 is legal; it writes and leaves the bit at 0.

Reset
REQ-036 Rst high immediately forces WrEn=0, Rw=0, busW=0, all busy bits 0, and the last-grant flag to ALU (load wins the first conflict).
REQ-037 Reset during a pending write drops that write; no write occurs after Rst deasserts.
REQ-038 AluRdy and MemRdy are 0 while Rst is high.

Structure
REQ-039 Shared package rf_pkg holds NREG, AW, DW and the grant enum {GNT_ALU, GNT_MEM}.
REQ-040 The busy vector, its set/clear logic and the BusyA/BusyB lookup live in sub-module rf_scoreboard; the arbiter and output register stay in rf_wb_arb.

Verification
REQ-041 AluVld=1, AluRw=18, AluBus=0x0000000A, no load request -> AluRdy=1; next cycle WrEn=1, Rw=18, busW=0x0000000A.
REQ-042 Both valid for 3 cycles, MemRw=19/0x2, AluRw=20/0x3000, after reset -> grants in order Mem, Alu, Mem; WrEn high on 3 consecutive cycles.
REQ-043 IssEn=1, IssRd=17; next cycle Ra=17 -> BusyA=1; ALU transfer to 17 -> BusyA stays 1 during the WrEn cycle and is 0 the cycle after.
REQ-044 Same edge: IssRd=5 and a transfer with Rw=5 -> busy[5]=1 after the edge.
REQ-045 MemVld=1, MemRw=0, MemBus=0xFFFFFFFF -> MemRdy=1; WrEn stays 0; BusyA for Ra=0 is 0.
REQ-046 Rst pulsed the cycle after a transfer to register 8 -> WrEn=0 immediately; BusyA=0 for Ra=8; no write issued after release.
